clock_period_meter: RTL
=======================

# clock_period_meter

- Measures the period and high time of a slow, asynchronous square wave, such as the output of the team's clock divider.
- Results are given in cycles of the system clock.
- Serves as the receive-side check of a divided clock: it recovers the divisor and duty split from the waveform.
- Used in self-test and bring-up logic to confirm divider settings on hardware.

## Interface
Parameters:
- WIDTH, 28: width of the cycle counter and result registers.
- TIMEOUT, 28'd1000: maximum cycles spent waiting in ARM or MEASURE before abort. Legal range is 2 ≤ TIMEOUT ≤ 2^WIDTH−1.

Ports:
- clock  input  1  system clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- sigIn  input  1  waveform under measurement; asynchronous to clock.
- start  input  1  single-cycle request to take one measurement.
- period  output  WIDTH  clock cycles between two successive rising edges of sigIn.
- highTime  output  WIDTH  clock cycles sigIn was high within that period.
- valid  output  1  one-cycle pulse: period/highTime updated.
- timeout  output  1  one-cycle pulse: measurement aborted.
- busy  output  1  high while not in IDLE, or during reset holdoff.

## Operation
- **Input conditioning**
  - sigIn passes through a 2-flop synchronizer, then a registered previous-value flop.
  - rise = sync & ~prev; fall = ~sync & prev.
  - All three flops reset to 0.
- **Reset holdoff**
  - After reset deasserts, a 2-bit holdoff counter keeps busy high and ignores start for 3 cycles.
  - This suppresses spurious edges caused by the synchronizer reset.
- **States**
  - IDLE: waits for start. start=1 while not busy: count ← 0, go to ARM.
  - ARM: waits for rise. On rise: count ← 1, seenFall ← 0, go to MEASURE. Otherwise count increments.
  - MEASURE: count increments each cycle.
    - On fall (first one only): highTime ← count, seenFall ← 1.
    - On rise: period ← count; highTime ← 0 if seenFall=0; go to DONE.
  - DONE: valid=1 for one cycle, then IDLE.
- **Timeout**
  - In ARM or MEASURE, if count reaches TIMEOUT with no rise in that cycle: timeout=1 for one cycle and go to IDLE.
  - period and highTime are left unchanged on timeout.
  - A rise in the same cycle count reaches TIMEOUT takes priority over the timeout.
- **Result registers**
  - period and highTime hold their values until the next valid.
  - Both reset to 0.
- **Width rule**
  - count never exceeds TIMEOUT, so it cannot wrap.
- **Start while busy**
  - start received when busy=1 is ignored, not queued.
- **Reset mid-operation**
  - All state clears immediately to reset values; no valid or timeout is issued.

## Timing
- **Reset values:** period=0, highTime=0, valid=0, timeout=0, busy=1 (holdoff), state=IDLE.
- **Edge detection latency:** a sigIn transition is flagged as rise or fall 2–3 clock cycles after it occurs, depending on metastability resolution.
- **Reported values:** period equals the number of clock cycles between the two detected rises. highTime equals the number of cycles between the rise and the fall.
- **valid:** asserted the cycle after the second rise is detected. period and highTime are already updated in that same cycle.
- **busy:** goes high the cycle after an accepted start. Goes low in the cycle after valid or timeout.
- **Accuracy:** sigIn edges within ±1 cycle jitter give results within ±1.
- **Minimum measurable waveform:** sigIn high ≥ 2 cycles and low ≥ 2 cycles. Shorter pulses may be missed.

## Test plan
- sigIn from a clock divider (DIVISOR=4, same clock), start pulse → valid within 12 cycles of start; period=4, highTime=2.
- Divider with DIVISOR=10, two back-to-back measurements (second start after valid) → both report period=10, highTime=5; busy low between them.
- sigIn held 0, TIMEOUT=100, start → timeout pulse 100 cycles after ARM entry; valid never asserts; period/highTime retain prior values.
- Second start pulse issued while in MEASURE → ignored; exactly one valid; results unchanged from the single-measurement case.
- reset asserted mid-MEASURE → outputs return to 0 immediately and busy stays high 3 cycles after release. A start during that holdoff is ignored; a later start measures correctly.
- sigIn driven high at reset release, then toggled with period 6 and start issued at the end of holdoff → no spurious short period; reports period=6, highTime=3.

Source files
------------

// File: rtl/clock_period_meter.sv
// clock_period_meter: measures period and high time of a slow asynchronous square wave in system clock cycles
module clock_period_meter #(
   parameter int               WIDTH   = 28,
   parameter logic [WIDTH-1:0] TIMEOUT = 28'd1000
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             sigIn,
   input  logic             start,
   output logic [WIDTH-1:0] period,
   output logic [WIDTH-1:0] highTime,
   output logic             valid,
   output logic             timeout,
   output logic             busy
);
   typedef enum logic [1:0] {IDLE, ARM, MEASURE, DONE} state_t;
   state_t           state_q, state_d;
   logic             sync1_q, sync2_q, prev_q;
   logic [1:0]       hold_q;
   logic [WIDTH-1:0] count_q, count_d, hcap_q, hcap_d, period_q, period_d, high_q, high_d;
   logic             seen_fall_q, seen_fall_d;
   logic             rise, fall, at_limit;
   assign rise     = sync2_q & ~prev_q;
   assign fall     = ~sync2_q & prev_q;
   assign at_limit = count_q == TIMEOUT;
   assign period   = period_q;
   assign highTime = high_q;
   assign valid    = state_q == DONE;
   assign busy     = state_q != IDLE || hold_q != 2'd0;
   // two-flop synchronizer plus previous-value flop for edge detection
   always_ff @(posedge clock or posedge reset)
      if (reset) {sync1_q, sync2_q, prev_q} <= 3'b000;
      else {sync1_q, sync2_q, prev_q} <= {sigIn, sync1_q, sync2_q};
   // holdoff after reset masks the spurious edge the cleared synchronizer can produce
   always_ff @(posedge clock or posedge reset)
      if (reset) hold_q <= 2'd3;
      else if (hold_q != 2'd0) hold_q <= hold_q - 2'd1;
   // state, counter and result registers
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         state_q     <= IDLE;
         count_q     <= '0;
         hcap_q      <= '0;
         seen_fall_q <= 1'b0;
         period_q    <= '0;
         high_q      <= '0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         hcap_q      <= hcap_d;
         seen_fall_q <= seen_fall_d;
         period_q    <= period_d;
         high_q      <= high_d;
      end
   // next state; high time is staged in hcap so results only change together at completion
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      hcap_d      = hcap_q;
      seen_fall_d = seen_fall_q;
      period_d    = period_q;
      high_d      = high_q;
      timeout     = 1'b0;
      case (state_q)
         IDLE:
            if (start && hold_q == 2'd0) begin
               count_d = '0;
               state_d = ARM;
            end
         ARM:
            if (rise) begin
               count_d     = WIDTH'(1);
               seen_fall_d = 1'b0;
               state_d     = MEASURE;
            end else if (at_limit) begin
               timeout = 1'b1;
               state_d = IDLE;
            end else count_d = count_q + WIDTH'(1);
         MEASURE:
            if (rise) begin
               period_d = count_q;
               high_d   = seen_fall_q ? hcap_q : '0;
               state_d  = DONE;
            end else if (at_limit) begin
               timeout = 1'b1;
               state_d = IDLE;
            end else begin
               count_d = count_q + WIDTH'(1);
               if (fall && !seen_fall_q) begin
                  hcap_d      = count_q;
                  seen_fall_d = 1'b1;
               end
            end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
endmodule
